// File: rtl/alu_div.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with fast-path handling of divide-by-zero and signed overflow.
//
// state | meaning
// IDLE  | waiting for i_start with a supported op
// CALC  | one restoring-division step per cycle, DATA_WIDTH steps
// DONE  | result presented on o_c, o_valid pulses for this one cycle
module alu_div #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [5:0]            i_alu_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_c
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  localparam logic [5:0] OP_DIV  = 6'b101101;
  localparam logic [5:0] OP_DIVU = 6'b101111;
  localparam logic [5:0] OP_REM  = 6'b110001;
  localparam logic [5:0] OP_REMU = 6'b110011;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  quo, rem, dvs;
  logic          is_rem, neg_q, neg_r;

  logic          op_ok, op_sgn, op_rem, ovf, special;
  logic [W-1:0]  a_abs, b_abs, spec_res;
  logic [W:0]    shifted, diff;
  logic [W-1:0]  step_q, step_r, fix_res;

  always_comb begin
    op_ok   = (i_alu_op == OP_DIV) || (i_alu_op == OP_DIVU) ||
              (i_alu_op == OP_REM) || (i_alu_op == OP_REMU);
    op_sgn  = (i_alu_op == OP_DIV) || (i_alu_op == OP_REM);
    op_rem  = (i_alu_op == OP_REM) || (i_alu_op == OP_REMU);
    ovf     = op_sgn && (i_a == {1'b1, {(W-1){1'b0}}}) && (i_b == '1);
    special = (i_b == '0) || ovf;
    a_abs   = (op_sgn && i_a[W-1]) ? -i_a : i_a;
    b_abs   = (op_sgn && i_b[W-1]) ? -i_b : i_b;
    if (i_b == '0) spec_res = op_rem ? i_a : '1;
    else           spec_res = op_rem ? '0 : i_a;
  end

  // Full W+1-bit partial remainder so divisors with the MSB set still divide correctly.
  always_comb begin
    shifted = {rem, quo[W-1]};
    diff    = shifted - {1'b0, dvs};
    if (!diff[W]) begin
      step_r = diff[W-1:0];
      step_q = {quo[W-2:0], 1'b1};
    end else begin
      step_r = shifted[W-1:0];
      step_q = {quo[W-2:0], 1'b0};
    end
    if (is_rem) fix_res = neg_r ? -step_r : step_r;
    else        fix_res = neg_q ? -step_q : step_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      is_rem  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_c     <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start && op_ok) begin
            is_rem <= op_rem;
            neg_q  <= op_sgn && (i_a[W-1] ^ i_b[W-1]);
            neg_r  <= op_sgn && i_a[W-1];
            quo    <= a_abs;
            rem    <= '0;
            dvs    <= b_abs;
            cnt    <= '0;
            o_busy <= 1'b1;
            if (special) begin
              state   <= S_DONE;
              o_valid <= 1'b1;
              o_c     <= spec_res;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          quo <= step_q;
          rem <= step_r;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state   <= S_DONE;
            o_valid <= 1'b1;
            o_c     <= fix_res;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div.sv
// Self-checking bench for alu_div: directed vector table, hand-written corner
// sequences, and randomized operations against an arithmetic reference model.
module tb_alu_div;

  localparam logic [5:0] OP_DIV  = 6'b101101;
  localparam logic [5:0] OP_DIVU = 6'b101111;
  localparam logic [5:0] OP_REM  = 6'b110001;
  localparam logic [5:0] OP_REMU = 6'b110011;
  localparam logic [5:0] OP_ADD  = 6'b000000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [5:0]  i_alu_op = '0;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        o_busy, o_valid;
  logic [31:0] o_c;

  int n_cmp = 0;
  int n_bad = 0;

  alu_div #(.DATA_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_alu_op(i_alu_op),
    .i_a(i_a), .i_b(i_b), .o_busy(o_busy), .o_valid(o_valid), .o_c(o_c)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // RISC-V division semantics in plain integer arithmetic.
  function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, r;
    sa = a;
    sb = b;
    case (op)
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = sa / sb;
        return r;
      end
      default: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        r = sa % sb;
        return r;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 0;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  // Issues one request, scrambles the inputs after acceptance, and checks latency,
  // busy-throughout, and the single-cycle valid pulse. Returns the result seen.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, output logic [31:0] res);
    int  lat;
    bit  busy_ok;
    @(negedge i_clk);
    i_start = 1'b1; i_alu_op = op; i_a = a; i_b = b;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_alu_op = 6'($urandom); i_a = $urandom; i_b = $urandom;
    lat = 0;
    busy_ok = 1'b1;
    while (!o_valid && lat < 60) begin
      if (!o_busy) busy_ok = 1'b0;
      @(posedge i_clk); #1;
      lat++;
    end
    check({tag, " busy"}, {31'b0, busy_ok & o_busy}, 32'd1);
    check({tag, " latency"}, lat, exp_lat(op, a, b));
    res = o_c;
    @(posedge i_clk); #1;
    check({tag, " valid pulse"}, {31'b0, o_valid}, 32'd0);
    check({tag, " busy clear"}, {31'b0, o_busy}, 32'd0);
    check({tag, " hold"}, o_c, res);
  endtask

  vec_t vecs[$];
  logic [31:0] res;

  initial begin
    vecs.push_back('{OP_DIVU, 32'd100, 32'd7, 32'd14, "divu 100/7"});
    vecs.push_back('{OP_REMU, 32'd100, 32'd7, 32'd2, "remu 100/7"});
    vecs.push_back('{OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem -7/2"});
    vecs.push_back('{OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div -7/2"});
    vecs.push_back('{OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, "div 5/0"});
    vecs.push_back('{OP_REMU, 32'd5, 32'd0, 32'd5, "remu 5/0"});
    vecs.push_back('{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div ovf"});
    vecs.push_back('{OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem ovf"});
    vecs.push_back('{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "divu no ovf"});
    vecs.push_back('{OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, "div -100/-7"});
    vecs.push_back('{OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, "rem 100/-7"});
    vecs.push_back('{OP_DIV, 32'h8000_0000, 32'd1, 32'h8000_0000, "div min/1"});
    vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, "divu big"});
    vecs.push_back('{OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, "remu big"});

    #12;
    check("reset busy", {31'b0, o_busy}, 32'd0);
    check("reset valid", {31'b0, o_valid}, 32'd0);
    check("reset c", o_c, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].name, res);
      check({vecs[i].name, " result"}, res, vecs[i].exp);
    end

    // Unsupported op is ignored.
    @(negedge i_clk);
    i_start = 1'b1; i_alu_op = OP_ADD; i_a = 32'd1; i_b = 32'd1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk); #1;
      check("add ignored valid", {31'b0, o_valid}, 32'd0);
      check("add ignored busy", {31'b0, o_busy}, 32'd0);
    end

    // Second start mid-CALC is ignored.
    @(negedge i_clk);
    i_start = 1'b1; i_alu_op = OP_DIVU; i_a = 32'd100; i_b = 32'd7;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (5) @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b1; i_alu_op = OP_REMU; i_a = 32'd50; i_b = 32'd3;
    @(negedge i_clk);
    i_start = 1'b0;
    begin
      int w;
      w = 0;
      while (!o_valid && w < 60) begin
        @(posedge i_clk); #1;
        w++;
      end
      check("midcalc latency", w, 32 - 6);
      check("midcalc result", o_c, 32'd14);
    end
    // Start in the valid cycle is ignored too.
    i_start = 1'b1; i_alu_op = OP_DIVU; i_a = 32'd9; i_b = 32'd3;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check("start in done busy", {31'b0, o_busy}, 32'd0);
    repeat (2) @(posedge i_clk); #1;
    check("start in done valid", {31'b0, o_valid}, 32'd0);

    // Async reset mid-CALC.
    @(negedge i_clk);
    i_start = 1'b1; i_alu_op = OP_DIVU; i_a = 32'd100; i_b = 32'd7;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (10) @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check("rst busy", {31'b0, o_busy}, 32'd0);
    check("rst valid", {31'b0, o_valid}, 32'd0);
    check("rst c", o_c, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (3) begin
      @(posedge i_clk); #1;
      check("rst no valid", {31'b0, o_valid}, 32'd0);
    end
    run_op(OP_DIVU, 32'd9, 32'd3, "divu 9/3", res);
    check("divu 9/3 result", res, 32'd3);

    // Randomized operations against the reference model.
    for (int n = 0; n < 60; n++) begin
      logic [5:0]  op;
      logic [31:0] a, b;
      case ($urandom_range(3))
        0: op = OP_DIV;
        1: op = OP_DIVU;
        2: op = OP_REM;
        default: op = OP_REMU;
      endcase
      a = $urandom;
      case ($urandom_range(7))
        0: b = 32'd0;
        1: b = $urandom_range(15);
        2: b = 32'hFFFF_FFFF;
        3: b = -32'($urandom_range(100));
        default: b = $urandom;
      endcase
      if ($urandom_range(15) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      run_op(op, a, b, "rand", res);
      check("rand result", res, model(op, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
